ccm_ctr_sched: RTL and testbench

Sequencer for the CCM counter-mode keystream core (`ccm_ctr_dly_fake_aes` or the real AES counter core, same port contract). It accepts one message request (nonce, flag, block count), clears the core counter, and issues one-cycle `input_en_buf` pulses under a credit limit. It buffers the in-order `encrypt_data` results in a small FIFO and hands them to the downstream CCM XOR stage over a valid/ready stream that marks the last block.

---
 rtl/ccm_ctr_sched.sv | 173 +++++++++++++++++
 tb/tb_ccm_ctr_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccm_ctr_sched.sv
// ccm_ctr_sched: sequencer for the CCM counter-mode keystream core.
// Takes one message request, clears the core counter, issues credit-limited
// input_en_buf pulses, buffers in-order results in a small FIFO and streams
// them downstream with a last-block marker.
module ccm_ctr_sched #(
  parameter int unsigned WIDTH_NONCE = 100,
  parameter int unsigned WIDTH_FLAG  = 8,
  parameter int unsigned WIDTH_COUNT = 20,
  parameter int unsigned WIDTH_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ISSUE_GAP   = 2,
  localparam int unsigned WIDTH_KEY  = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT
) (
  input  logic                   clk,
  input  logic                   kill,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH_NONCE-1:0] req_nonce,
  input  logic [WIDTH_FLAG-1:0]  req_flag,
  input  logic [WIDTH_LEN-1:0]   req_nblk,
  output logic [WIDTH_NONCE-1:0] ctr_nonce,
  output logic [WIDTH_FLAG-1:0]  ctr_flag,
  output logic                   ctr_clr,
  output logic                   ctr_en,
  input  logic [WIDTH_KEY-1:0]   core_data,
  input  logic                   core_en,
  output logic [WIDTH_KEY-1:0]   ks_data,
  output logic                   ks_valid,
  input  logic                   ks_ready,
  output logic                   ks_last,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned PW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CW         = PW + 1;
  localparam int unsigned GW         = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int unsigned GAP_RELOAD = (ISSUE_GAP > 1) ? ISSUE_GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t               state;
  logic [WIDTH_LEN-1:0] nblk_q;
  logic [WIDTH_LEN-1:0] remain;
  logic [WIDTH_LEN-1:0] pop_cnt;
  logic [WIDTH_LEN-1:0] last_idx;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        fifo_cnt;
  logic [CW:0]          credit_used;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [GW-1:0]        gap_cnt;
  logic [WIDTH_KEY-1:0] mem [FIFO_DEPTH];

  logic credit_ok;
  logic issue;
  logic fifo_full;
  logic push;
  logic pop;
  logic pop_last;

  // Issue/accept/push/pop decisions, all from registered state
  always_comb begin
    credit_used = {1'b0, outstanding} + {1'b0, fifo_cnt};
    credit_ok   = credit_used < (CW + 1)'(FIFO_DEPTH);
    // The first pulse is decided while in CLR so it lands the cycle after ctr_clr
    issue       = ((state == S_CLR) || (state == S_ISSUE)) && credit_ok && (gap_cnt == '0);
    fifo_full   = (fifo_cnt == CW'(FIFO_DEPTH));
    push        = core_en && (outstanding != '0) && !fifo_full;
    pop         = ks_valid && ks_ready;
    last_idx    = nblk_q - WIDTH_LEN'(1);
    pop_last    = pop && (pop_cnt == last_idx);
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign ks_valid  = (fifo_cnt != '0);
  assign ks_data   = mem[rd_ptr];
  assign ks_last   = ks_valid && (pop_cnt == last_idx);

  // Message FSM with registered core-facing outputs and block counters
  always_ff @(posedge clk) begin
    if (kill) begin
      state     <= S_IDLE;
      ctr_clr   <= 1'b0;
      ctr_en    <= 1'b0;
      ctr_nonce <= '0;
      ctr_flag  <= '0;
      nblk_q    <= '0;
      remain    <= '0;
      pop_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      ctr_clr <= 1'b0;
      ctr_en  <= issue;
      if (issue) begin
        remain  <= remain - WIDTH_LEN'(1);
        gap_cnt <= GW'(GAP_RELOAD);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      if (pop) begin
        pop_cnt <= pop_cnt + WIDTH_LEN'(1);
      end
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            ctr_nonce <= req_nonce;
            ctr_flag  <= req_flag;
            nblk_q    <= req_nblk;
            remain    <= req_nblk;
            pop_cnt   <= '0;
            gap_cnt   <= '0;
            if (req_nblk != '0) begin
              state   <= S_CLR;
              ctr_clr <= 1'b1;
            end
          end
        end
        S_CLR: begin
          state <= (issue && (remain == WIDTH_LEN'(1))) ? S_DRAIN : S_ISSUE;
        end
        S_ISSUE: begin
          if (issue && (remain == WIDTH_LEN'(1))) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop_last) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Credit, FIFO occupancy/pointers and sticky protocol error
  always_ff @(posedge clk) begin
    if (kill) begin
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err         <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(push);
      fifo_cnt    <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (core_en && !push) begin
        err <= 1'b1;
      end
    end
  end

  // Keystream storage; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= core_data;
    end
  end

endmodule

// File: tb/tb_ccm_ctr_sched.sv
// Self-checking bench for ccm_ctr_sched: a latency-10 core model feeds the
// DUT; a block-level model predicts keystream contents, order, last marker,
// issue spacing and credit bound.
module tb_ccm_ctr_sched;

  localparam int unsigned NW    = 100;
  localparam int unsigned FW    = 8;
  localparam int unsigned CNTW  = 20;
  localparam int unsigned LEN_W = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned KW    = NW + FW + CNTW;
  localparam int unsigned LAT   = 10;

  logic            clk = 1'b0;
  logic            kill;
  logic            req_valid;
  logic            req_ready;
  logic [NW-1:0]   req_nonce;
  logic [FW-1:0]   req_flag;
  logic [LEN_W-1:0] req_nblk;
  logic [NW-1:0]   ctr_nonce;
  logic [FW-1:0]   ctr_flag;
  logic            ctr_clr;
  logic            ctr_en;
  logic [KW-1:0]   core_data;
  logic            core_en;
  logic [KW-1:0]   ks_data;
  logic            ks_valid;
  logic            ks_ready;
  logic            ks_last;
  logic            busy;
  logic            err;

  logic            spur_en;
  logic [KW-1:0]   spur_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ccm_ctr_sched #(
    .WIDTH_NONCE(NW),
    .WIDTH_FLAG (FW),
    .WIDTH_COUNT(CNTW),
    .WIDTH_LEN  (LEN_W),
    .FIFO_DEPTH (DEPTH),
    .ISSUE_GAP  (GAP)
  ) dut (
    .clk      (clk),
    .kill     (kill),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_nonce(req_nonce),
    .req_flag (req_flag),
    .req_nblk (req_nblk),
    .ctr_nonce(ctr_nonce),
    .ctr_flag (ctr_flag),
    .ctr_clr  (ctr_clr),
    .ctr_en   (ctr_en),
    .core_data(core_data),
    .core_en  (core_en),
    .ks_data  (ks_data),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .ks_last  (ks_last),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core stand-in: counter cleared by ctr_clr, result = {nonce, flag, count}
  // returned LAT cycles after each input_en_buf pulse
  logic [LAT-1:0]  pv;
  logic [KW-1:0]   pd [LAT];
  logic [CNTW-1:0] ccnt;

  always_ff @(posedge clk) begin
    if (kill) begin
      pv   <= '0;
      ccnt <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], ctr_en};
      pd[0] <= {ctr_nonce, ctr_flag, ccnt};
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
      if (ctr_clr) ccnt <= '0;
      else if (ctr_en) ccnt <= ccnt + CNTW'(1);
    end
  end

  assign core_en   = pv[LAT-1] | spur_en;
  assign core_data = spur_en ? spur_data : pd[LAT-1];

  // Reference model state, written by the stimulus process
  logic [NW-1:0] exp_nonce;
  logic [FW-1:0] exp_flag;
  int unsigned   exp_nblk = 0;
  int unsigned   pop_base = 0;

  // Observation counters, written only by the monitor
  int unsigned iss_total = 0;
  int unsigned pop_total = 0;
  int unsigned crd_iss   = 0;
  int unsigned crd_pop   = 0;
  int unsigned cyc       = 0;
  int unsigned last_en   = 0;
  bit          have_prev = 0;

  // Stream monitor: block i of a message must be {nonce, flag, i}, last only at i = nblk-1
  always @(negedge clk) begin
    int unsigned idx;
    cyc++;
    if (kill) begin
      crd_iss   = 0;
      crd_pop   = 0;
      have_prev = 0;
    end else begin
      if (ctr_clr) have_prev = 0;
      if (ctr_en) begin
        iss_total++;
        crd_iss++;
        if (have_prev) check("issue_gap", 128'((cyc - last_en) >= GAP), 128'(1));
        check("credit_bound", 128'((crd_iss - crd_pop) <= DEPTH), 128'(1));
        last_en   = cyc;
        have_prev = 1;
      end
      if (ks_valid && ks_ready) begin
        idx = pop_total - pop_base;
        check("ks_data", ks_data, {exp_nonce, exp_flag, CNTW'(idx)});
        check("ks_last", 128'(ks_last), 128'(idx == exp_nblk - 1));
        pop_total++;
        crd_pop++;
      end
    end
  end

  task automatic start_req(input logic [NW-1:0] nonce, input logic [FW-1:0] flag,
                           input int unsigned nblk);
    @(posedge clk); #1;
    exp_nonce = nonce;
    exp_flag  = flag;
    exp_nblk  = nblk;
    pop_base  = pop_total;
    req_valid = 1'b1;
    req_nonce = nonce;
    req_flag  = flag;
    req_nblk  = LEN_W'(nblk);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // mode 0: ks_ready high, mode 1: random ks_ready
  task automatic wait_done(input string tag, input int unsigned nblk, input int unsigned i0,
                           input int mode, input int unsigned budget);
    bit done = 0;
    for (int unsigned c = 0; c < budget && !done; c++) begin
      if (!busy) done = 1;
      else begin
        ks_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    end
    ks_ready = 1'b1;
    check({tag, "_done"}, 128'(done), 128'(1));
    check({tag, "_issues"}, 128'(iss_total - i0), 128'(nblk));
    check({tag, "_pops"}, 128'(pop_total - pop_base), 128'(nblk));
    check({tag, "_ready"}, 128'(req_ready), 128'(1));
  endtask

  task automatic run_msg(input string tag, input logic [NW-1:0] nonce, input logic [FW-1:0] flag,
                         input int unsigned nblk, input int mode, input int unsigned budget);
    int unsigned i0 = iss_total;
    start_req(nonce, flag, nblk);
    wait_done(tag, nblk, i0, mode, budget);
    check({tag, "_nonce_held"}, 128'(ctr_nonce), 128'(nonce));
    check({tag, "_flag_held"}, 128'(ctr_flag), 128'(flag));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'(1));
    check({tag, "_ctr_clr"}, 128'(ctr_clr), 128'(0));
    check({tag, "_ctr_en"}, 128'(ctr_en), 128'(0));
    check({tag, "_ks_valid"}, 128'(ks_valid), 128'(0));
    check({tag, "_ks_last"}, 128'(ks_last), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_err"}, 128'(err), 128'(0));
    check({tag, "_ctr_nonce"}, 128'(ctr_nonce), 128'(0));
    check({tag, "_ctr_flag"}, 128'(ctr_flag), 128'(0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned i0;
    int clr_k, en_k, core_k, val_k, rdy_k;
    bit last_at_val, busy_k1, saw_bad;
    logic [KW-1:0] sp;

    kill      = 1'b1;
    req_valid = 1'b0;
    req_nonce = '0;
    req_flag  = '0;
    req_nblk  = '0;
    ks_ready  = 1'b1;
    spur_en   = 1'b0;
    spur_data = '0;
    repeat (2) @(posedge clk);
    #1 kill = 1'b0;
    check_reset("por");

    // Single block: cycle-exact latency from acceptance
    clr_k = -1; en_k = -1; core_k = -1; val_k = -1; rdy_k = -1;
    last_at_val = 0; busy_k1 = 0;
    i0 = iss_total;
    start_req(100'h123456789abcdef0123456789, 8'h5a, 1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) busy_k1 = busy;
      if (ctr_clr && clr_k < 0) clr_k = k;
      if (ctr_en && en_k < 0) en_k = k;
      if (core_en && core_k < 0) core_k = k;
      if (ks_valid && val_k < 0) begin val_k = k; last_at_val = ks_last; end
      if (req_ready && rdy_k < 0) rdy_k = k;
      @(posedge clk); #1;
    end
    check("one_busy_c1", 128'(busy_k1), 128'(1));
    check("one_clr_cycle", 128'(clr_k), 128'(1));
    check("one_en_cycle", 128'(en_k), 128'(2));
    check("one_core_cycle", 128'(core_k), 128'(12));
    check("one_valid_cycle", 128'(val_k), 128'(13));
    check("one_last_at_valid", 128'(last_at_val), 128'(1));
    check("one_ready_cycle", 128'(rdy_k), 128'(14));
    check("one_issues", 128'(iss_total - i0), 128'(1));

    // Backpressure: credit stops issue at FIFO_DEPTH blocks
    ks_ready = 1'b0;
    i0 = iss_total;
    start_req(100'hfeedface0cafe, 8'h33, 8);
    repeat (40) @(posedge clk);
    #1;
    check("bp_stall_issues", 128'(iss_total - i0), 128'(4));
    check("bp_stall_valid", 128'(ks_valid), 128'(1));
    check("bp_stall_busy", 128'(busy), 128'(1));
    wait_done("bp", 8, i0, 0, 300);

    // Zero-length request
    i0 = iss_total;
    saw_bad = 0;
    start_req(100'h77, 8'h01, 0);
    for (int k = 0; k < 6; k++) begin
      if (!req_ready || busy || ctr_clr || ctr_en) saw_bad = 1;
      @(posedge clk); #1;
    end
    check("nblk0_quiet", 128'(saw_bad), 128'(0));
    check("nblk0_issues", 128'(iss_total - i0), 128'(0));

    // Kill held two cycles mid-message, then a normal message
    ks_ready = 1'b0;
    start_req(100'habcabc, 8'h99, 8);
    repeat (15) @(posedge clk);
    #1 kill = 1'b1;
    repeat (2) @(posedge clk);
    #1 kill = 1'b0;
    check_reset("kill");
    ks_ready = 1'b1;
    run_msg("after_kill", 100'h0badc0de, 8'hc3, 5, 0, 300);

    // Largest block count for the configured length width
    run_msg("max_len", 100'h1f2e3d4c5b6a, 8'he7, (1 << LEN_W) - 1, 0, 10000);

    // Spurious core_en while idle
    sp = '0;
    for (int unsigned b = 0; b < 16; b++) sp[127 - 8*b -: 8] = 8'(b + 1);
    @(posedge clk); #1;
    spur_data = sp;
    spur_en   = 1'b1;
    @(posedge clk); #1;
    spur_en = 1'b0;
    check("spur_err", 128'(err), 128'(1));
    check("spur_ks_valid", 128'(ks_valid), 128'(0));
    run_msg("spur_next", 100'h5555, 8'h11, 3, 0, 300);
    check("spur_err_sticky", 128'(err), 128'(1));
    @(posedge clk); #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    check("spur_err_cleared", 128'(err), 128'(0));

    // Randomized messages with random downstream backpressure
    for (int m = 0; m < 8; m++) begin
      logic [NW-1:0] rn;
      logic [FW-1:0] rf;
      int unsigned   rb;
      rn = {$urandom, $urandom, $urandom, $urandom};
      rf = FW'($urandom);
      rb = $urandom_range(1, 24);
      run_msg("rand", rn, rf, rb, 1, 3000);
    end
    check("final_err", 128'(err), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
